uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter that sits directly downstream of the memory controller's UART store decode. It accepts one byte per cycle from the store path into a DEPTH-entry FIFO and serialises bytes as 8N1 frames on `uart_tx`. A CPU store therefore never stalls on line rate unless the FIFO is full. Status outputs (`full`, `empty`, `count`, `busy`, `overflow`) are exported for a memory-mapped status register.

## Interface
- `CLK_HZ`, default 27000000: core clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: push request; sampled every rising edge.
- `wr_data` in 8: byte to push.
- `uart_tx` out 1: serial output; idles high.
- `full` out 1: high when count == DEPTH.
- `empty` out 1: high when count == 0.
- `count` out $clog2(DEPTH)+1: number of bytes currently held.
- `busy` out 1: high whenever the serialiser state is not IDLE.
- `overflow` out 1: sticky; set when a push is dropped because the FIFO is full.

## Operation
- `CLKS_PER_BIT` = CLK_HZ / BAUD, using integer (truncating) division. With the defaults this is 234.
- **FIFO**
  - Circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH.
  - `count` is a separate register.
  - A push occurs when `wr_en` is high and `full` is low (the registered value before the edge).
  - A push while full is dropped and sets `overflow` at that edge. `overflow` is cleared only by `reset`.
  - A pop is requested by the serialiser only when `empty` is low.
  - Push and pop in the same cycle leave `count` unchanged; both pointers advance.
  - Push while full is dropped even if a pop happens in the same cycle.
- **Serialiser FSM**: states IDLE, START, DATA, STOP.
  - IDLE: `uart_tx`=1. If `empty`=0: pop the head byte into the shift register, clear the baud counter and the bit index, then go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send bit 0 first (LSB first). Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles.
    - On the last STOP cycle, if `empty`=0: pop, load the next byte and go straight to START, with no idle gap.
    - Otherwise go to IDLE.
- **Baud counter**: counts 0..CLKS_PER_BIT-1, wraps to 0, and is reset on every state entry.
- **Output register**: `uart_tx` is driven from a flop, so there is no combinational path from inputs.
- **Reset values**: `uart_tx`=1, state IDLE, `count`=0, both pointers 0, `empty`=1, `full`=0, `busy`=0, `overflow`=0.
- **Reset mid-frame**: the frame is aborted and FIFO contents are discarded. `uart_tx` is 1 after the reset edge.

## Timing
- **Push visibility**: a push at edge E0 makes `empty`=0 and `count`+1 visible after E0.
- **Frame start latency**: from IDLE, a pop happens at E1 (the next edge). `uart_tx` falls and `busy` rises after E1, i.e. 2 edges after `wr_en` is sampled.
- **Frame length**: exactly 10×CLKS_PER_BIT cycles. The start bit occupies cycles [E1, E1+CLKS_PER_BIT); the stop bit ends at E1+10×CLKS_PER_BIT.
- **Back-to-back frames**: the next start bit begins at E1+10×CLKS_PER_BIT. `busy` stays high throughout.
- **Throughput**: sustained throughput is 1 byte per 10×CLKS_PER_BIT cycles. Peak input rate is 1 byte per cycle until full.
- **Flag timing**: `full`, `empty`, `count` and `overflow` are registered and update at the same edge as the push or pop that changes them.

## Test plan
All directed tests use CLK_HZ=16, BAUD=4 (CLKS_PER_BIT=4) and DEPTH=4.

1. **Reset values**: hold `reset` for 2 cycles → `uart_tx`=1, `empty`=1, `full`=0, `count`=0, `busy`=0, `overflow`=0.
2. **Single byte**: push 0xA5 at E0 →
   - `uart_tx` falls after E1.
   - Bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - `busy` falls at E1+40 and `count` returns to 0.
3. **Burst and overflow**: push 0x01..0x06 on 6 consecutive edges →
   - The first byte pops at the edge after its push; 0x02..0x05 fill the FIFO (`count` reaches 4, `full`=1).
   - 0x06 is dropped and `overflow`=1.
   - Frames 0x01..0x05 go out back-to-back with no idle high between stop and start (5×40 cycles).
4. **Simultaneous push/pop**: FIFO holds 1 byte, IDLE and empty=0; push 0x3C on the edge where the serialiser pops → `count` stays 1. Serial order is the old byte, then 0x3C.
5. **Reset mid-frame**: push 0xFF, then assert `reset` during DATA bit 3 → `uart_tx`=1, `count`=0, `busy`=0 after the reset edge. A subsequent push of 0x00 produces a clean full frame.
6. **Pointer wrap**: push and drain 10 distinct bytes in groups of 3 → all 10 appear serially in order, and `overflow` stays 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Store-path / status bundle for the buffered UART transmitter.
// master: store decode side (drives wr_en/wr_data, reads the status flags).
// slave : uart_tx_fifo (accepts bytes, drives full/empty/count/busy/overflow).
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, busy, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a DEPTH-entry byte FIFO fed one byte per
// cycle from the store path, drained by a serialiser onto uart_tx.
// Ports:
//   clk     - single core clock, rising edge
//   reset   - synchronous, active-high
//   bus     - slave side of uart_tx_fifo_if (wr_en/wr_data in, status out)
//   uart_tx - registered serial output, idles high
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module uart_tx_fifo #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_fifo_if.slave bus,
  output logic         uart_tx
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          full_q, empty_q, ovf_q;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt, pop, push, baud_last;

  // Push decision uses the registered full flag, so a simultaneous pop
  // never rescues a push into a full FIFO.
  assign push      = bus.wr_en & ~full_q;
  assign baud_last = (baud_cnt == BW'(CPB - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shreg_nxt = shreg;
    bit_nxt   = bit_idx;
    case (state)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_last) state_nxt = DATA;
      end
      DATA: begin
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            shreg_nxt = shreg >> 1;
            bit_nxt   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (!empty_q) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (pop) begin
      shreg_nxt = mem[rd_ptr];
      bit_nxt   = 3'd0;
    end

    // The line level is a function of where the FSM will be after this edge,
    // which keeps uart_tx a pure flop output.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase

    if (state_nxt != state || baud_last || state == IDLE)
      baud_nxt = '0;
    else
      baud_nxt = baud_cnt + BW'(1);

    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      uart_tx  <= tx_nxt;
      count_q  <= count_nxt;
      full_q   <= (count_nxt == CW'(DEPTH));
      empty_q  <= (count_nxt == '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; contents are only meaningful via count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state != IDLE);
endmodule
